// File: rtl/master_burst_fsm_if.sv
// Byte link between master_burst_fsm and slave_fsm: four-phase req/ack plus the offered byte.
interface master_burst_fsm_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic              req;
    logic              ack;
    logic [DATA_W-1:0] data;

    modport master (output req, output data, input ack);
    modport slave  (input req, input data, output ack);
endinterface

// File: rtl/master_burst_fsm.sv
// Burst master: buffers BURST_LEN bytes from the host and sends them over a four-phase
// req/ack link, with a per-state stall timeout that aborts the burst and raises err.
module master_burst_fsm #(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [3:0]        load_idx,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    master_burst_fsm_if.master link,
    output logic              busy,
    output logic [3:0]        byte_idx,
    output logic              done,
    output logic              err
);

    localparam int unsigned IdxW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [4:0]  LenL    = 5'(BURST_LEN);
    localparam logic [3:0]  LastIdx = 4'(BURST_LEN - 1);
    localparam logic [7:0]  ToLast  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StSend, StWaitLow, StDone} state_e;

    state_e            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] buf_q [BURST_LEN];
    logic [DATA_W-1:0] buf_d [BURST_LEN];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        cnt_d   = '0;  // any state change restarts the stall counter
        buf_d   = buf_q;

        // Writes are only accepted while idle so the offered byte cannot change mid-burst.
        if (load_en && (state_q == StIdle) && ({1'b0, load_idx} < LenL)) begin
            buf_d[load_idx[IdxW-1:0]] = load_data;
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (link.ack) begin
                    state_d = StWaitLow;
                end else if (cnt_q == ToLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StWaitLow: begin
                if (!link.ack) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = StSend;
                    end
                end else if (cnt_q == ToLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            buf_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    assign link.req  = (state_q == StSend);
    assign link.data = buf_q[idx_q[IdxW-1:0]];
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign byte_idx  = idx_q;
    assign err       = err_q;

endmodule
